// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file with pending-write scoreboard.
// Busy vectors are carried at a fixed maximum width so one popcount serves any depth up to 256.
package reg_file_pkg;

    localparam int REG_ZERO_ADDR = 0;
    localparam int BUSY_MAX_W    = 256;

    typedef logic [BUSY_MAX_W-1:0] busy_vec_t;

    function automatic int unsigned popcount(input busy_vec_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < BUSY_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: address decode, write bypass, zero-register mask, and busy lookup.
// With REG_FILE_SYNC_READ_EN defined the data and busy outputs are registered (1-cycle latency).
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SELECTOR = 5,
    parameter int ZERO_REG = 1,
    parameter int DEPTH    = 2**SELECTOR
) (
`ifdef REG_FILE_SYNC_READ_EN
    input  logic                   i_clk,
    input  logic                   i_rst_n,
`endif
    input  logic [SELECTOR-1:0]    i_addr,
    input  logic [DEPTH*WIDTH-1:0] i_regs_flat,
    input  logic [DEPTH-1:0]       i_busy,
    input  logic                   i_wr_en,
    input  logic [SELECTOR-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_busy_set,
    input  logic [SELECTOR-1:0]    i_busy_reg,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_busy
);

    logic             w_zero_hit;
    logic             w_bypass;
    logic             w_reset_same;
    logic [WIDTH-1:0] w_data;
    logic             w_busy;

    assign w_zero_hit   = (ZERO_REG != 0) && (i_addr == SELECTOR'(REG_ZERO_ADDR));
    assign w_bypass     = i_wr_en && (i_wr_addr == i_addr) && !w_zero_hit;
    // A same-edge re-issue to this register keeps it pending even though it is written now.
    assign w_reset_same = i_busy_set && !i_flush && (i_busy_reg == i_addr);

    always_comb begin
        w_data = i_regs_flat[i_addr*WIDTH +: WIDTH];
        w_busy = i_busy[i_addr];
        if (w_zero_hit) begin
            w_data = '0;
            w_busy = 1'b0;
        end else if (w_bypass) begin
            w_data = i_wr_data;
            w_busy = w_reset_same;
        end
    end

`ifdef REG_FILE_SYNC_READ_EN
    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else begin
            r_data <= w_data;
            r_busy <= w_busy;
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;
`else
    assign o_data = w_data;
    assign o_busy = w_busy;
`endif

endmodule

// File: rtl/reg_file_scoreboard.sv
// Multi-read-port register file with write bypass, optional hardwired zero register and
// per-register pending-write scoreboard. Optional registered reads: REG_FILE_SYNC_READ_EN.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SELECTOR = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Reg_Write_i,
    input  logic [SELECTOR-1:0]          Write_Register_i,
    input  logic [WIDTH-1:0]             Write_Data_i,
    input  logic [NUM_READ*SELECTOR-1:0] Read_Register_i,
    output logic [NUM_READ*WIDTH-1:0]    Read_Data_o,
    output logic [NUM_READ-1:0]          Read_Busy_o,
    input  logic                         Busy_Set_i,
    input  logic [SELECTOR-1:0]          Busy_Register_i,
    input  logic                         Flush_i,
    output logic [SELECTOR:0]            Busy_Count_o
);

    localparam int DEPTH = 2**SELECTOR;
    localparam int CNT_W = SELECTOR + 1;

    logic [WIDTH-1:0]       r_regs [DEPTH];
    logic [DEPTH-1:0]       r_busy;
    logic [CNT_W-1:0]       r_busy_count;

    logic [DEPTH*WIDTH-1:0] w_regs_flat;
    logic [DEPTH-1:0]       w_busy_next;
    busy_vec_t              w_busy_ext;
    logic                   w_wr_zero;
    logic                   w_set_zero;

    assign w_wr_zero  = (ZERO_REG != 0) && (Write_Register_i == SELECTOR'(REG_ZERO_ADDR));
    assign w_set_zero = (ZERO_REG != 0) && (Busy_Register_i == SELECTOR'(REG_ZERO_ADDR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (Reg_Write_i && !w_wr_zero) begin
            r_regs[Write_Register_i] <= Write_Data_i;
        end
    end

    // Clear on writeback first, then set, so a same-edge re-issue leaves the register pending.
    always_comb begin
        w_busy_next = r_busy;
        if (Flush_i) begin
            w_busy_next = '0;
        end else begin
            if (Reg_Write_i && !w_wr_zero) begin
                w_busy_next[Write_Register_i] = 1'b0;
            end
            if (Busy_Set_i && !w_set_zero) begin
                w_busy_next[Busy_Register_i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy_ext = '0;
        w_busy_ext[DEPTH-1:0] = w_busy_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_next;
            r_busy_count <= CNT_W'(popcount(w_busy_ext));
        end
    end

    assign Busy_Count_o = r_busy_count;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign w_regs_flat[i*WIDTH +: WIDTH] = r_regs[i];
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        reg_file_read_port #(
            .WIDTH    (WIDTH),
            .SELECTOR (SELECTOR),
            .ZERO_REG (ZERO_REG),
            .DEPTH    (DEPTH)
        ) u_rd (
`ifdef REG_FILE_SYNC_READ_EN
            .i_clk       (clk),
            .i_rst_n     (rst),
`endif
            .i_addr      (Read_Register_i[k*SELECTOR +: SELECTOR]),
            .i_regs_flat (w_regs_flat),
            .i_busy      (r_busy),
            .i_wr_en     (Reg_Write_i),
            .i_wr_addr   (Write_Register_i),
            .i_wr_data   (Write_Data_i),
            .i_busy_set  (Busy_Set_i),
            .i_busy_reg  (Busy_Register_i),
            .i_flush     (Flush_i),
            .o_data      (Read_Data_o[k*WIDTH +: WIDTH]),
            .o_busy      (Read_Busy_o[k])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard (default build: combinational reads, ZERO_REG=1).
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        bset;
    logic [4:0]  breg;
    logic        flush;
    logic [5:0]  cnt;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    reg_file_scoreboard #(
        .WIDTH(32), .SELECTOR(5), .NUM_READ(2), .ZERO_REG(1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Reg_Write_i      (we),
        .Write_Register_i (wa),
        .Write_Data_i     (wd),
        .Read_Register_i  (ra),
        .Read_Data_o      (rd),
        .Read_Busy_o      (rbusy),
        .Busy_Set_i       (bset),
        .Busy_Register_i  (breg),
        .Flush_i          (flush),
        .Busy_Count_o     (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic s, input logic [4:0] sr, input logic f);
        @(posedge clk);
        #1;
        we = w; wa = a; wd = d;
        ra = {r1, r0};
        bset = s; breg = sr; flush = f;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic [5:0] c);
        exp_t e;
        e.name = nm; e.d0 = d0; e.d1 = d1; e.busy = b; e.cnt = c;
        q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle; compare everything queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (rd[31:0] !== e.d0 || rd[63:32] !== e.d1 || rbusy !== e.busy || cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s: got d0=%h d1=%h busy=%b cnt=%0d, want d0=%h d1=%h busy=%b cnt=%0d",
                         e.name, rd[31:0], rd[63:32], rbusy, cnt, e.d0, e.d1, e.busy, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b0;
        we = 0; wa = 0; wd = 0; ra = 0; bset = 0; breg = 0; flush = 0;

        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);
            push_exp("reset_read", 0, 0, 2'b00, 0);
        end

        drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        rst = 1'b1;
        push_exp("bypass_same_cycle", 32'hDEADBEEF, 0, 2'b00, 0);
        drive(0, 0, 0, 5, 5, 0, 0, 0);
        push_exp("read_after_write_dual", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        drive(1, 0, 32'h12345678, 0, 5, 0, 0, 0);
        push_exp("zero_reg_write_bypass", 0, 32'hDEADBEEF, 2'b00, 0);
        drive(0, 0, 0, 0, 5, 1, 0, 0);
        push_exp("zero_reg_read", 0, 32'hDEADBEEF, 2'b00, 0);
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        push_exp("zero_reg_never_busy", 0, 32'hDEADBEEF, 2'b00, 0);

        drive(0, 0, 0, 7, 9, 1, 7, 0);
        push_exp("set7_issue", 0, 0, 2'b00, 0);
        drive(0, 0, 0, 7, 9, 1, 9, 0);
        push_exp("set9_issue", 0, 0, 2'b01, 1);
        drive(1, 7, 32'h77, 7, 9, 0, 0, 0);
        push_exp("write7_masks_busy", 32'h77, 0, 2'b10, 2);
        drive(1, 9, 32'h99, 7, 9, 1, 9, 0);
        push_exp("set_write9_same_edge", 32'h77, 32'h99, 2'b10, 1);
        drive(0, 0, 0, 7, 9, 0, 0, 0);
        push_exp("reg9_still_busy", 32'h77, 32'h99, 2'b10, 1);

        drive(0, 0, 0, 1, 4, 1, 1, 0);
        push_exp("set1", 0, 0, 2'b00, 1);
        drive(0, 0, 0, 1, 4, 1, 2, 0);
        push_exp("set2", 0, 0, 2'b01, 2);
        drive(0, 0, 0, 1, 4, 1, 3, 0);
        push_exp("set3", 0, 0, 2'b01, 3);
        drive(0, 0, 0, 1, 4, 1, 4, 0);
        push_exp("set4", 0, 0, 2'b01, 4);
        drive(0, 0, 0, 4, 6, 1, 6, 1);
        push_exp("flush_with_set", 0, 0, 2'b01, 5);
        drive(0, 0, 0, 6, 9, 0, 0, 0);
        push_exp("after_flush", 0, 32'h99, 2'b00, 0);

        drive(1, 12, 32'hCAFE, 12, 13, 1, 13, 0);
        push_exp("pre_reset_write", 32'hCAFE, 0, 2'b00, 0);
        drive(0, 0, 0, 12, 13, 0, 0, 0);
        push_exp("pre_reset_state", 32'hCAFE, 0, 2'b10, 1);
        drive(0, 0, 0, 12, 13, 0, 0, 0);
        rst = 1'b0;
        push_exp("midstream_reset", 0, 0, 2'b00, 0);
        drive(1, 12, 32'h1111, 12, 13, 0, 0, 0);
        rst = 1'b1;
        push_exp("first_write_after_reset", 32'h1111, 0, 2'b00, 0);
        drive(0, 0, 0, 12, 13, 0, 0, 0);
        push_exp("write_after_reset_held", 32'h1111, 0, 2'b00, 0);

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
